// File: rtl/traffic_pkg.sv
// Shared light codes, phase-state encoding and field widths
// for the intersection phase scheduler.
package traffic_pkg;

  localparam int LW = 2;

  localparam logic [LW-1:0] RED    = 2'd0;
  localparam logic [LW-1:0] YELLOW = 2'd1;
  localparam logic [LW-1:0] GREEN  = 2'd2;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_WALK   = 2'd3
  } phase_t;

endpackage

// File: rtl/rr_next_pick.sv
// Round-robin search for the next approach to serve after the
// active one; falls back to the home approach 0 when nobody waits.
module rr_next_pick #(
  parameter int N_APPR = 4,
  parameter int IDX_W  = $clog2(N_APPR)
) (
  input  logic [N_APPR-1:0] req,
  input  logic [IDX_W-1:0]  active,
  output logic [IDX_W-1:0]  tgt,
  output logic              valid
);

  always_comb begin
    tgt   = '0;
    valid = 1'b0;
    // descending so the nearest requester after active wins
    for (int k = N_APPR - 1; k >= 1; k--) begin
      if (req[(int'(active) + k) % N_APPR]) begin
        tgt   = IDX_W'((int'(active) + k) % N_APPR);
        valid = 1'b1;
      end
    end
    if (!valid && active != '0) begin
      tgt   = '0;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Round-robin green/yellow/all-red phase scheduler for one intersection.
// Optional pedestrian walk phase: define PED_WALK_EN.
import traffic_pkg::*;

module intersection_phase_scheduler #(
  parameter int N_APPR    = 4,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6,
  parameter int IDX_W     = $clog2(N_APPR)
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 tick,
  input  logic [N_APPR-1:0]    req,
  output logic [2*N_APPR-1:0]  lights,
  output logic [IDX_W-1:0]     active,
  output logic                 phase_start
`ifdef PED_WALK_EN
  ,
  input  logic                 ped_req,
  output logic                 walk
`endif
);

  localparam int TW = $clog2(MAX_GREEN + 1);
  localparam logic [TW-1:0] TMR_MAX = TW'(MAX_GREEN);
  localparam logic [TW-1:0] Y_LAST  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] A_LAST  = TW'(ALLRED_T - 1);

  phase_t           state;
  logic [TW-1:0]    tmr;
  logic [IDX_W-1:0] nxt;
  logic             fresh;
  logic [IDX_W-1:0] rr_tgt;
  logic             rr_valid;
  logic [IDX_W-1:0] tgt;
  logic             has_tgt;
  logic             go;
  int               tmr_p1;

  rr_next_pick #(
    .N_APPR (N_APPR),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req    (req),
    .active (active),
    .tgt    (rr_tgt),
    .valid  (rr_valid)
  );

`ifdef PED_WALK_EN
  localparam logic [TW-1:0] W_LAST = TW'(WALK_T - 1);
  logic ped_pend;
  logic post_walk;

  assign has_tgt = rr_valid | ped_pend;
  assign tgt     = rr_valid ? rr_tgt : active;
  assign walk    = (state == PH_WALK);
`else
  assign has_tgt = rr_valid;
  assign tgt     = rr_tgt;
`endif

  always_comb begin
    tmr_p1 = int'(tmr) + 1;
    go = (state == PH_GREEN) && has_tgt
      && (tmr_p1 >= MIN_GREEN)
      && (!req[active] || tmr_p1 >= MAX_GREEN);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= PH_GREEN;
      active      <= '0;
      tmr         <= '0;
      nxt         <= '0;
      phase_start <= 1'b0;
      fresh       <= 1'b1;
`ifdef PED_WALK_EN
      ped_pend    <= 1'b0;
      post_walk   <= 1'b0;
`endif
    end else begin
      phase_start <= fresh;
      fresh       <= 1'b0;
      if (tick) begin
        if (tmr != TMR_MAX) tmr <= tmr + 1'b1;
        unique case (state)
          PH_GREEN: if (go) begin
            state <= PH_YELLOW;
            nxt   <= tgt;
            tmr   <= '0;
          end
          PH_YELLOW: if (tmr == Y_LAST) begin
            state <= PH_ALLRED;
            tmr   <= '0;
          end
          PH_ALLRED: if (tmr == A_LAST) begin
            tmr <= '0;
`ifdef PED_WALK_EN
            if (ped_pend && !post_walk) begin
              state    <= PH_WALK;
              ped_pend <= 1'b0;
            end else begin
              state       <= PH_GREEN;
              active      <= nxt;
              phase_start <= 1'b1;
              post_walk   <= 1'b0;
            end
`else
            state       <= PH_GREEN;
            active      <= nxt;
            phase_start <= 1'b1;
`endif
          end
          PH_WALK: begin
`ifdef PED_WALK_EN
            if (tmr == W_LAST) begin
              state     <= PH_ALLRED;
              tmr       <= '0;
              post_walk <= 1'b1;
            end
`else
            state <= PH_GREEN;
`endif
          end
          default: state <= PH_GREEN;
        endcase
      end
`ifdef PED_WALK_EN
      // a request during walk entry re-arms the next walk
      if (ped_req) ped_pend <= 1'b1;
`endif
    end
  end

  always_comb begin
    lights = '0;
    for (int i = 0; i < N_APPR; i++) begin
      if (i == int'(active)) begin
        if (state == PH_GREEN)
          lights[2*i +: LW] = GREEN;
        else if (state == PH_YELLOW)
          lights[2*i +: LW] = YELLOW;
        else
          lights[2*i +: LW] = RED;
      end
    end
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler (N_APPR=4, tick=1).
// Walk scenario is built only when PED_WALK_EN is defined.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       tick = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] lights;
  logic [1:0] active;
  logic       phase_start;
`ifdef PED_WALK_EN
  logic       ped_req = 1'b0;
  logic       walk;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  intersection_phase_scheduler dut (
    .clk         (clk),
    .clear       (clear),
    .tick        (tick),
    .req         (req),
    .lights      (lights),
    .active      (active),
    .phase_start (phase_start)
`ifdef PED_WALK_EN
    ,
    .ped_req     (ped_req),
    .walk        (walk)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= clear ? 0 : cyc + 1;

  task automatic do_reset();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic advance_to(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int ps_cnt;
    req = 4'b0000;
    do_reset();
    n_cmp++;
    if (lights !== 8'h02 || active !== 2'd0 || phase_start !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state lights=%h active=%0d ps=%b exp 02/0/0",
               lights, active, phase_start);
    end
    ps_cnt = 0;
    for (int e = 1; e <= 40; e++) begin
      advance_to(e);
      if (phase_start === 1'b1) ps_cnt++;
      if (e == 1) begin
        n_cmp++;
        if (phase_start !== 1'b1) begin
          n_bad++;
          $display("FAIL reset_pulse got=%b exp=1", phase_start);
        end
      end
      n_cmp++;
      if (lights !== 8'h02 || active !== 2'd0) begin
        n_bad++;
        $display("FAIL home_rest cyc=%0d lights=%h active=%0d exp 02/0",
                 e, lights, active);
      end
    end
    n_cmp++;
    if (ps_cnt != 1) begin
      n_bad++;
      $display("FAIL reset_pulse_count got=%0d exp=1", ps_cnt);
    end
  endtask

  task automatic test_min_green();
    req = 4'b0100;
    do_reset();
    for (int e = 1; e <= 4; e++) begin
      advance_to(e);
      n_cmp++;
      if (lights !== 8'h02) begin
        n_bad++;
        $display("FAIL min_green_hold cyc=%0d got=%h exp=02", e, lights);
      end
    end
    advance_to(5);
    n_cmp++;
    if (lights !== 8'h01) begin
      n_bad++;
      $display("FAIL min_yellow got=%h exp=01", lights);
    end
    advance_to(7);
    n_cmp++;
    if (lights !== 8'h01) begin
      n_bad++;
      $display("FAIL min_yellow_end got=%h exp=01", lights);
    end
    advance_to(8);
    n_cmp++;
    if (lights !== 8'h00) begin
      n_bad++;
      $display("FAIL min_allred got=%h exp=00", lights);
    end
    advance_to(9);
    n_cmp++;
    if (lights !== 8'h20 || active !== 2'd2 || phase_start !== 1'b1) begin
      n_bad++;
      $display("FAIL min_green2 lights=%h active=%0d ps=%b exp 20/2/1",
               lights, active, phase_start);
    end
    req = 4'b0000;
    advance_to(10);
    n_cmp++;
    if (phase_start !== 1'b0) begin
      n_bad++;
      $display("FAIL min_ps_width got=%b exp=0", phase_start);
    end
    advance_to(13);
    n_cmp++;
    if (lights !== 8'h20) begin
      n_bad++;
      $display("FAIL home_return_hold got=%h exp=20", lights);
    end
    advance_to(14);
    n_cmp++;
    if (lights !== 8'h10 || active !== 2'd2) begin
      n_bad++;
      $display("FAIL home_return_yellow lights=%h active=%0d exp 10/2",
               lights, active);
    end
    advance_to(18);
    n_cmp++;
    if (lights !== 8'h02 || active !== 2'd0 || phase_start !== 1'b1) begin
      n_bad++;
      $display("FAIL home_return_green lights=%h active=%0d ps=%b exp 02/0/1",
               lights, active, phase_start);
    end
  endtask

  task automatic test_max_green();
    req = 4'b0011;
    do_reset();
    for (int e = 1; e <= 19; e++) begin
      advance_to(e);
      n_cmp++;
      if (lights !== 8'h02) begin
        n_bad++;
        $display("FAIL max_green_hold cyc=%0d got=%h exp=02", e, lights);
      end
    end
    advance_to(20);
    n_cmp++;
    if (lights !== 8'h01) begin
      n_bad++;
      $display("FAIL max_yellow got=%h exp=01", lights);
    end
    advance_to(23);
    n_cmp++;
    if (lights !== 8'h00) begin
      n_bad++;
      $display("FAIL max_allred got=%h exp=00", lights);
    end
    advance_to(24);
    n_cmp++;
    if (lights !== 8'h08 || active !== 2'd1 || phase_start !== 1'b1) begin
      n_bad++;
      $display("FAIL max_green1 lights=%h active=%0d ps=%b exp 08/1/1",
               lights, active, phase_start);
    end
  endtask

  task automatic test_round_robin();
    req = 4'b1001;
    advance_to(28);
    n_cmp++;
    if (lights !== 8'h08) begin
      n_bad++;
      $display("FAIL rr_green1_hold got=%h exp=08", lights);
    end
    advance_to(29);
    n_cmp++;
    if (lights !== 8'h04) begin
      n_bad++;
      $display("FAIL rr_yellow1 got=%h exp=04", lights);
    end
    advance_to(33);
    n_cmp++;
    if (lights !== 8'h80 || active !== 2'd3) begin
      n_bad++;
      $display("FAIL rr_green3 lights=%h active=%0d exp 80/3",
               lights, active);
    end
    advance_to(52);
    n_cmp++;
    if (lights !== 8'h80) begin
      n_bad++;
      $display("FAIL rr_green3_max got=%h exp=80", lights);
    end
    advance_to(53);
    n_cmp++;
    if (lights !== 8'h40) begin
      n_bad++;
      $display("FAIL rr_yellow3 got=%h exp=40", lights);
    end
    advance_to(57);
    n_cmp++;
    if (lights !== 8'h02 || active !== 2'd0) begin
      n_bad++;
      $display("FAIL rr_green0 lights=%h active=%0d exp 02/0",
               lights, active);
    end
  endtask

  task automatic test_clear_in_yellow();
    req = 4'b0100;
    do_reset();
    advance_to(6);
    n_cmp++;
    if (lights !== 8'h01) begin
      n_bad++;
      $display("FAIL clr_pre_yellow got=%h exp=01", lights);
    end
    do_reset();
    n_cmp++;
    if (lights !== 8'h02 || active !== 2'd0 || phase_start !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_abort lights=%h active=%0d ps=%b exp 02/0/0",
               lights, active, phase_start);
    end
    advance_to(4);
    n_cmp++;
    if (lights !== 8'h02) begin
      n_bad++;
      $display("FAIL clr_tmr_restart got=%h exp=02", lights);
    end
    advance_to(5);
    n_cmp++;
    if (lights !== 8'h01) begin
      n_bad++;
      $display("FAIL clr_tmr_yellow got=%h exp=01", lights);
    end
  endtask

`ifdef PED_WALK_EN
  task automatic test_ped_walk();
    req = 4'b0000;
    do_reset();
    advance_to(1);
    ped_req = 1'b1;
    advance_to(2);
    ped_req = 1'b0;
    advance_to(4);
    n_cmp++;
    if (lights !== 8'h02) begin
      n_bad++;
      $display("FAIL ped_green got=%h exp=02", lights);
    end
    advance_to(5);
    n_cmp++;
    if (lights !== 8'h01) begin
      n_bad++;
      $display("FAIL ped_yellow got=%h exp=01", lights);
    end
    advance_to(8);
    n_cmp++;
    if (lights !== 8'h00 || walk !== 1'b0) begin
      n_bad++;
      $display("FAIL ped_allred1 lights=%h walk=%b exp 00/0", lights, walk);
    end
    for (int e = 9; e <= 14; e++) begin
      advance_to(e);
      n_cmp++;
      if (lights !== 8'h00 || walk !== 1'b1) begin
        n_bad++;
        $display("FAIL ped_walk cyc=%0d lights=%h walk=%b exp 00/1",
                 e, lights, walk);
      end
    end
    advance_to(15);
    n_cmp++;
    if (lights !== 8'h00 || walk !== 1'b0) begin
      n_bad++;
      $display("FAIL ped_allred2 lights=%h walk=%b exp 00/0", lights, walk);
    end
    advance_to(16);
    n_cmp++;
    if (lights !== 8'h02 || active !== 2'd0 || phase_start !== 1'b1) begin
      n_bad++;
      $display("FAIL ped_home lights=%h active=%0d ps=%b exp 02/0/1",
               lights, active, phase_start);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_min_green();
    test_max_green();
    test_round_robin();
    test_clear_in_yellow();
`ifdef PED_WALK_EN
    test_ped_walk();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
